// File: rtl/uart_pkg.sv
// Shared types and register map for the Wishbone UART receiver.
// Holds the FSM state enum, register selects, status bit positions and the STATUS word builder.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

  localparam logic UART_REG_DATA   = 1'b0;
  localparam logic UART_REG_STATUS = 1'b1;

  localparam int ST_VALID   = 0;
  localparam int ST_OVERRUN = 1;
  localparam int ST_FRAME   = 2;

  // STATUS layout: fill count in the top byte, sticky flags and valid in the low bits.
  function automatic logic [31:0] pack_status(input logic [7:0] fill,
                                              input logic       frame_err,
                                              input logic       overrun,
                                              input logic       valid);
    logic [31:0] word;
    word             = 32'h0000_0000;
    word[31:24]      = fill;
    word[ST_FRAME]   = frame_err;
    word[ST_OVERRUN] = overrun;
    word[ST_VALID]   = valid;
    return word;
  endfunction

endpackage

// File: rtl/wb_uart_rx_if.sv
// Wishbone classic bus bundle between the core (master) and the UART receiver (slave).
interface wb_uart_rx_if;
  logic        CYC;
  logic        STB;
  logic        WE;
  logic [31:0] ADR;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        ACK;
  logic        ERR;
  logic        RTY;

  modport master (output CYC, STB, WE, ADR, DAT_I,
                  input  DAT_O, ACK, ERR, RTY);

  modport slave  (input  CYC, STB, WE, ADR, DAT_I,
                  output DAT_O, ACK, ERR, RTY);
endinterface

// File: rtl/wb_uart_rx_fifo.sv
// Receive byte FIFO with wrap-bit pointers; a pop frees space for a push in the same cycle.
// A pop on an empty FIFO is ignored, so a simultaneous push into an empty FIFO still lands.
module uart_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [DEPTH];
  logic          do_push_s;
  logic          do_pop_s;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: it is only observed behind a non-empty FIFO.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/wb_uart_rx.sv
// Wishbone slave UART receiver: 8N1 deserialiser feeding a byte FIFO, with DATA and STATUS registers.
// Received bytes appear in DAT_O[31:24]; irq stays high while any byte is waiting.
module wb_uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  wb_uart_rx_if.slave       bus,
  output logic              irq
);

  localparam int TW = $clog2(CLK_DIV);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLK_DIV / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(CLK_DIV - 1);

  logic           rx_meta_q;
  logic           rx_sync_q;
  logic           rx_s;

  uart_rx_state_t state_q,     state_d;
  logic [TW-1:0]  timer_q,     timer_d;
  logic [2:0]     bit_idx_q,   bit_idx_d;
  logic [7:0]     shift_q,     shift_d;
  logic           overrun_q,   overrun_d;
  logic           frame_err_q, frame_err_d;
  logic           ack_q,       ack_d;
  logic [31:0]    dat_o_q,     dat_o_d;

  logic           req_s;
  logic           rd_data_s;
  logic           wr_status_s;
  logic           fifo_push_s;
  logic           fifo_pop_s;
  logic           set_ovr_s;
  logic           set_fe_s;
  logic [7:0]     fifo_dout_s;
  logic           fifo_empty_s;
  logic           fifo_full_s;
  logic [CW-1:0]  fifo_count_s;
  logic           unused_bits;

  assign rx_s        = rx_sync_q;
  assign req_s       = bus.CYC & bus.STB & ~ack_q;
  assign rd_data_s   = req_s & ~bus.WE & (bus.ADR[2] == UART_REG_DATA);
  assign wr_status_s = req_s &  bus.WE & (bus.ADR[2] == UART_REG_STATUS);
  assign fifo_pop_s  = rd_data_s & ~fifo_empty_s;

  assign bus.ACK   = ack_q;
  assign bus.DAT_O = dat_o_q;
  assign bus.ERR   = 1'b0;
  assign bus.RTY   = 1'b0;
  assign irq       = ~fifo_empty_s;
  assign unused_bits = ^{bus.ADR[31:3], bus.ADR[1:0], bus.DAT_I[31:3], bus.DAT_I[0]};

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .din   (shift_q),
    .dout  (fifo_dout_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s),
    .count (fifo_count_s)
  );

  // Receive FSM: every timed state counts down and acts when the timer reaches zero.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    fifo_push_s = 1'b0;
    set_ovr_s   = 1'b0;
    set_fe_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          timer_d = HALF_LOAD;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (timer_q != {TW{1'b0}}) begin
          timer_d = timer_q - TW'(1);
        end else if (!rx_s) begin
          timer_d   = FULL_LOAD;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (timer_q != {TW{1'b0}}) begin
          timer_d = timer_q - TW'(1);
        end else begin
          shift_d = {rx_s, shift_q[7:1]};
          timer_d = FULL_LOAD;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (timer_q != {TW{1'b0}}) begin
          timer_d = timer_q - TW'(1);
        end else begin
          state_d = IDLE;
          if (!rx_s) begin
            set_fe_s = 1'b1;
          end else if (fifo_full_s && !fifo_pop_s) begin
            set_ovr_s = 1'b1;
          end else begin
            fifo_push_s = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus side: single-cycle ACK, read data captured on the same edge, write-1-to-clear flags.
  always_comb begin
    ack_d       = req_s;
    dat_o_d     = dat_o_q;
    overrun_d   = (overrun_q   & ~(wr_status_s & bus.DAT_I[1])) | set_ovr_s;
    frame_err_d = (frame_err_q & ~(wr_status_s & bus.DAT_I[2])) | set_fe_s;
    if (req_s && !bus.WE) begin
      if (bus.ADR[2] == UART_REG_STATUS) begin
        dat_o_d = pack_status(8'(fifo_count_s), frame_err_q, overrun_q, ~fifo_empty_s);
      end else if (fifo_empty_s) begin
        dat_o_d = 32'h0000_0000;
      end else begin
        dat_o_d = {fifo_dout_s, 24'h00_0000};
      end
    end else begin
      dat_o_d = dat_o_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      state_q     <= IDLE;
      timer_q     <= {TW{1'b0}};
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      ack_q       <= 1'b0;
      dat_o_q     <= 32'h0000_0000;
    end else begin
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      ack_q       <= ack_d;
      dat_o_q     <= dat_o_d;
    end
  end

endmodule

// File: tb/tb_wb_uart_rx.sv
// Scoreboard bench for wb_uart_rx: bus reads queue expected data, a negedge monitor checks each ACK.
module tb_wb_uart_rx;
  import uart_pkg::*;

  localparam int CLK_DIV = 16;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic irq;

  always #5 clk = ~clk;

  wb_uart_rx_if bus();

  wb_uart_rx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (bus.slave),
    .irq (irq)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
    bit          chk;
  } txn_t;

  txn_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  logic prev_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every ACK must be a lone pulse and must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    txn_t t;
    if (bus.ACK === 1'b1) begin
      check("ack_single_pulse", {31'b0, prev_ack}, 32'h0);
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack actual=%h required=none", bus.DAT_O);
      end else begin
        t = sb_q.pop_front();
        if (t.chk) check(t.name, bus.DAT_O, t.exp);
      end
    end
    prev_ack = bus.ACK;
  end

  task automatic bus_xfer(input logic we, input logic adr2, input logic [31:0] wdata,
                          input string name, input logic [31:0] exp, input bit chk);
    int n;
    txn_t t;
    t.name = name;
    t.exp  = exp;
    t.chk  = chk;
    @(posedge clk); #1;
    sb_q.push_back(t);
    bus.CYC   = 1'b1;
    bus.STB   = 1'b1;
    bus.WE    = we;
    bus.ADR   = {29'b0, adr2, 2'b00};
    bus.DAT_I = wdata;
    n = 0;
    @(posedge clk); #1;
    while (!bus.ACK && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.ACK) begin
      total++;
      bad++;
      $display("FAIL ack_timeout %s actual=0 required=1", name);
    end
    bus.CYC = 1'b0;
    bus.STB = 1'b0;
    bus.WE  = 1'b0;
  endtask

  task automatic rd(input logic adr2, input string name, input logic [31:0] exp);
    bus_xfer(1'b0, adr2, 32'h0, name, exp, 1'b1);
  endtask

  task automatic wr(input logic adr2, input logic [31:0] data);
    bus_xfer(1'b1, adr2, data, "write", 32'h0, 1'b0);
  endtask

  task automatic hold_bit();
    repeat (CLK_DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(posedge clk); #1;
    rx = 1'b0;
    hold_bit();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      hold_bit();
    end
    rx = stop_bit;
    hold_bit();
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int n;
    logic [7:0] b;
    rst       = 1'b1;
    rx        = 1'b1;
    bus.CYC   = 1'b0;
    bus.STB   = 1'b0;
    bus.WE    = 1'b0;
    bus.ADR   = 32'h0;
    bus.DAT_I = 32'h0;
    idle(3);
    check("reset_ack",   {31'b0, bus.ACK}, 32'h0);
    check("reset_dat_o", bus.DAT_O, 32'h0);
    check("reset_irq",   {31'b0, irq}, 32'h0);
    check("err_rty",     {30'b0, bus.ERR, bus.RTY}, 32'h0);
    rst = 1'b0;
    idle(4);

    // 1: single byte, latency, STATUS and DATA
    lat = 0;
    fork
      send_frame(8'h41, 1'b1);
      begin
        @(posedge clk); #1;
        while (!irq && lat < 300) begin
          @(posedge clk); #1;
          lat++;
        end
      end
    join
    check("irq_latency_window", {31'b0, (lat >= 150 && lat <= 160)}, 32'h1);
    check("irq_after_byte", {31'b0, irq}, 32'h1);
    rd(UART_REG_STATUS, "t1_status", 32'h0100_0001);
    rd(UART_REG_DATA,   "t1_data",   32'h4100_0000);
    idle(2);
    check("t1_irq_cleared", {31'b0, irq}, 32'h0);
    rd(UART_REG_STATUS, "t1_status_empty", 32'h0000_0000);

    // 2: back-to-back frames, in-order reads, empty read
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    send_frame(8'h00, 1'b1);
    rd(UART_REG_DATA, "t2_d0", 32'h5500_0000);
    rd(UART_REG_DATA, "t2_d1", 32'hAA00_0000);
    rd(UART_REG_DATA, "t2_d2", 32'h0000_0000);
    rd(UART_REG_DATA, "t2_empty_read", 32'h0000_0000);
    rd(UART_REG_STATUS, "t2_status", 32'h0000_0000);

    // 3: overrun on the ninth byte
    for (int i = 1; i <= 9; i++) begin
      b = 8'(i);
      send_frame(b, 1'b1);
    end
    rd(UART_REG_STATUS, "t3_status_full", 32'h0800_0003);
    for (int i = 1; i <= 8; i++) begin
      rd(UART_REG_DATA, "t3_data", {8'(i), 24'h0});
    end
    rd(UART_REG_STATUS, "t3_status_drained", 32'h0000_0002);
    wr(UART_REG_STATUS, 32'h0000_0002);
    rd(UART_REG_STATUS, "t3_overrun_cleared", 32'h0000_0000);

    // 4: framing error
    send_frame(8'h3C, 1'b0);
    idle(40);
    check("t4_irq", {31'b0, irq}, 32'h0);
    rd(UART_REG_STATUS, "t4_frame_err", 32'h0000_0004);
    wr(UART_REG_STATUS, 32'h0000_0004);
    rd(UART_REG_STATUS, "t4_frame_cleared", 32'h0000_0000);

    // 5: short glitch while idle
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(40);
    check("t5_state_idle", {30'b0, dut.state_q}, {30'b0, IDLE});
    check("t5_irq", {31'b0, irq}, 32'h0);
    rd(UART_REG_STATUS, "t5_status", 32'h0000_0000);

    // 6: reset during bit 4, continuous strobe, then a clean byte
    b = 8'h7E;
    @(posedge clk); #1;
    rx = 1'b0;
    hold_bit();
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      hold_bit();
    end
    rx = b[4];
    idle(8);
    rst = 1'b1;
    rx  = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(20);
    for (int i = 0; i < 3; i++) begin
      txn_t t;
      t.name = "t6_burst_status";
      t.exp  = 32'h0000_0000;
      t.chk  = 1'b1;
      sb_q.push_back(t);
    end
    bus.CYC = 1'b1;
    bus.STB = 1'b1;
    bus.WE  = 1'b0;
    bus.ADR = {29'b0, UART_REG_STATUS, 2'b00};
    idle(6);
    bus.CYC = 1'b0;
    bus.STB = 1'b0;
    idle(3);
    send_frame(8'h7E, 1'b1);
    rd(UART_REG_STATUS, "t6_status", 32'h0100_0001);
    rd(UART_REG_DATA,   "t6_data",   32'h7E00_0000);
    rd(UART_REG_STATUS, "t6_status_after", 32'h0000_0000);

    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      idle(1);
      n++;
    end
    check("sb_drained", sb_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_uart_rx.md
Name: wb_uart_rx

Overview:
- Wishbone slave UART receiver: the receive-side counterpart of the console print path.
- Deserialises 8N1 frames from the `rx` pin into a byte FIFO. The core reads bytes and status over the shared Wishbone bus.
- Sits beside the RAM on the core's bus. The SoC decodes its CYC from the address; the block itself decodes only ADR[2].

Parameters:
- CLK_DIV, 16: clk cycles per bit period; must be ≥ 4 and even.
- FIFO_DEPTH, 8: receive FIFO entries; must be a power of 2, ≥ 2.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- rx  input  1  serial line, idle high, asynchronous to clk
- CYC  input  1  Wishbone cycle, already address-qualified by the SoC
- STB  input  1  Wishbone strobe
- WE  input  1  write enable
- ADR  input  32  byte address; only ADR[2] used (0 = DATA, 1 = STATUS)
- DAT_I  input  32  write data from the core
- DAT_O  output  32  read data to the core
- ACK  output  1  transfer acknowledge
- ERR  output  1  tied 0
- RTY  output  1  tied 0
- irq  output  1  high while the FIFO is non-empty

Behaviour:
- Reset (async, rst=1):
  - FSM → IDLE; FIFO empty; overrun = 0; frame_err = 0.
  - Both synchroniser flops = 1.
  - ACK = 0, DAT_O = 0, irq = 0.
  - Reset mid-frame discards the partial byte; no error flag is set.
- Synchroniser: rx passes through 2 flops (rx_s). The FSM uses only rx_s.
- Bit timer: down-counter, width $clog2(CLK_DIV).
- FSM (uart_rx_state_t):
  - IDLE: rx_s == 0 → load timer CLK_DIV/2-1, go START. Detection is level-based.
  - START: at timer 0, if rx_s == 0 → load CLK_DIV-1, bit_idx = 0, go DATA. Otherwise (glitch) → IDLE, with no flag.
  - DATA: at timer 0, shift = {rx_s, shift[7:1]} (LSB first) and reload CLK_DIV-1. After bit_idx 7 → STOP.
  - STOP: at timer 0:
    - rx_s == 1 → push shift into the FIFO. If the FIFO is full and no pop occurs that cycle, drop the byte and set overrun.
    - rx_s == 0 → discard the byte and set frame_err.
    - Either way → IDLE. A held-low line (break) therefore yields one frame_err per frame time.
- Latency: the byte is visible (irq = 1, STATUS[0] = 1) in the cycle after the stop-bit mid-sample. That is about 9.5 bit periods after the start edge, plus 2 synchroniser cycles.
- FIFO:
  - Read/write pointers are $clog2(FIFO_DEPTH)+1 bits wide. Full and empty are derived from the MSB and pointer equality.
  - Push and pop in the same cycle when full: both succeed, count unchanged, no overrun.
  - Push and pop in the same cycle when empty: the push succeeds, the pop is ignored, and the read returns 0.
- Wishbone:
  - ACK is registered: ACK <= CYC & STB & ~ACK. It is a single-cycle pulse, one wait state.
  - DAT_O is registered in the same edge as ACK.
  - Read DATA: DAT_O = {fifo_head, 24'h0}, matching the core's byte-in-[31:24] convention. The FIFO pops on that edge if non-empty. If empty, DAT_O = 0 and nothing pops.
  - Read STATUS: DAT_O = {fill_count[7:0], 21'h0, frame_err, overrun, ~empty}.
  - Write STATUS: DAT_I[1] = 1 clears overrun; DAT_I[2] = 1 clears frame_err (write-1-to-clear). If a set and a clear coincide, the set wins.
  - Write DATA: acknowledged, no effect.
  - When no ACK is issued, DAT_O holds its last value.

Decomposition:
- Package uart_pkg holds:
  - uart_rx_state_t enum {IDLE, START, DATA, STOP};
  - localparams UART_REG_DATA = 1'b0 and UART_REG_STATUS = 1'b1;
  - status bit indices ST_VALID = 0, ST_OVERRUN = 1, ST_FRAME = 2.
- One sub-module, uart_rx_fifo (parameter DEPTH; push/pop/din/dout/empty/full/count). The FSM, synchroniser and bus logic stay in wb_uart_rx.

Test Plan:
1. Reset, then send 0x41 (8N1) with CLK_DIV=16 → irq rises about 152 cycles after the start edge. STATUS read = 0x01000001; DATA read = 0x41000000; afterwards irq = 0 and STATUS = 0x00000000.
2. Send 0x55, 0xAA, 0x00 back-to-back → three DATA reads return 0x55000000, 0xAA000000, 0x00000000 in order. A fourth read returns 0 with no pop.
3. Send 9 bytes 0x01–0x09 without reading (FIFO_DEPTH=8) → STATUS = 0x08000003 (overrun set). Reads return 0x01–0x08. Write STATUS 0x2 → overrun clears.
4. Send 0x3C with the stop bit driven low → FIFO stays empty, STATUS bit2 = 1. Write STATUS 0x4 → bit2 = 0.
5. Drive a 4-cycle low glitch on rx while idle → no byte, no flags, FSM back in IDLE.
6. Assert rst during bit 4 of a frame, release, then send 0x7E → exactly one byte 0x7E read, no error flags; ACK is never high for 2 consecutive cycles under a continuous CYC&STB.
